ultrasonic_sensor_model: RTL and testbench
==========================================

# ultrasonic_sensor_model

Synthesizable responder model of an HC-SR04-style ultrasonic ranging sensor. It accepts the trigger pulse from the ultrasonic controller and answers with an echo pulse whose width in clock cycles is set by an input. It is used in hardware loopback builds and in simulation to drive the controller without a physical sensor. Trigger qualification, the burst delay, echo timeout and post-measurement hold-off follow the sensor's datasheet behaviour, scaled to clock cycles.

## Interface
- `MIN_TRIG_CYCLES`, default 250: minimum trigger high time that is accepted as valid (10 µs at 25 MHz).
- `DELAY_CYCLES`, default 5000: cycles from the end of a valid trigger to the echo rising edge. Must be ≥ 1.
- `ECHO_TIMEOUT`, default 950000: echo width used when no object is present (38 ms at 25 MHz).
- `HOLDOFF_CYCLES`, default 250000: quiet time after the echo falls, during which triggers are ignored. Must be ≥ 1.
- `WIDTH`, default 20: width of `echo_width_i` and of the internal counters.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low. While low, all state and all outputs are cleared.
- `trig_i`  in  1  trigger from the controller. Asynchronous to `clk`; synchronized internally.
- `echo_width_i`  in  WIDTH  requested echo width in cycles, sampled once per measurement.
- `echo_o`  out  1  echo pulse to the controller. Registered.
- `busy_o`  out  1  high while in DELAY, ECHO or HOLDOFF. Registered.
- `trig_err_o`  out  1  one-cycle pulse when a trigger is rejected as too short. Registered.

## Operation
- Input path: `trig_i` passes through two flops (`s1`, `s2`). A third flop `s3` holds the previous `s2` for edge detection.
  - Rise is `s2 & ~s3`.
  - Fall is `~s2 & s3`.
- States: IDLE, TRIG, DELAY, ECHO, HOLDOFF.
- IDLE:
  - On a rise, go to TRIG and load the counter with 1.
  - A trigger already high when IDLE is entered is ignored until it goes low and rises again.
- TRIG:
  - While `s2` is high, the counter increments and saturates at `MIN_TRIG_CYCLES`.
  - On a fall with count ≥ `MIN_TRIG_CYCLES`:
    - latch the width W, where W = `echo_width_i`, except W = `ECHO_TIMEOUT` if `echo_width_i` is 0 or greater than `ECHO_TIMEOUT`;
    - clear the counter and go to DELAY.
  - On a fall with count < `MIN_TRIG_CYCLES`: pulse `trig_err_o` for one cycle and return to IDLE.
- DELAY: count `DELAY_CYCLES` cycles, then go to ECHO with `echo_o` set.
- ECHO: `echo_o` stays high for exactly W cycles, then goes low and the FSM enters HOLDOFF.
- HOLDOFF: count `HOLDOFF_CYCLES` cycles, then go to IDLE. `trig_i` activity is ignored; no error pulse is raised.
- During DELAY and ECHO, `trig_i` activity is also ignored.
- Changes to `echo_width_i` after the latch point have no effect on the current measurement.
- Counter arithmetic is unsigned, WIDTH bits wide. Every parameter must fit in WIDTH bits.

## Timing
- Reset values: `echo_o` = 0, `busy_o` = 0, `trig_err_o` = 0, state IDLE, sync flops 0, counters 0.
- Reset asserted mid-measurement: `echo_o` and `busy_o` drop asynchronously. After release the FSM is in IDLE and the next action requires a fresh rise.
- Trigger high for P consecutive sampled cycles produces P cycles of `s2` high. The trigger is valid iff P ≥ `MIN_TRIG_CYCLES`.
- Let edge N be the first rising edge of `clk` that samples `trig_i` low after a valid pulse.
  - Edge N+2: the FSM enters DELAY and `busy_o` rises.
  - Edge N+2+`DELAY_CYCLES`: `echo_o` rises.
  - `echo_o` falls W edges after it rises.
  - `busy_o` falls `HOLDOFF_CYCLES` edges after `echo_o` falls.
- For a short trigger, `trig_err_o` is high for exactly the one cycle following edge N+2.
- Simultaneous rise and leaving HOLDOFF: no trigger is accepted. Only a rise seen while in IDLE starts a measurement.

## Test plan
All scenarios use `MIN_TRIG_CYCLES`=10, `DELAY_CYCLES`=8, `ECHO_TIMEOUT`=1000, `HOLDOFF_CYCLES`=20, `WIDTH`=16.
- Valid trigger: trigger high 10 cycles, `echo_width_i`=100.
  - Required: `echo_o` rises 10 cycles after trigger low is first sampled and stays high exactly 100 cycles.
  - Required: `busy_o` falls 20 cycles after `echo_o` falls.
- Short trigger: trigger high 9 cycles.
  - Required: one-cycle `trig_err_o` pulse, `echo_o` stays 0, `busy_o` stays 0.
- Timeout clamp, two runs:
  - `echo_width_i`=0: echo is 1000 cycles wide.
  - `echo_width_i`=5000: echo is 1000 cycles wide.
- Ignored triggers and latch point:
  - Retrigger (15-cycle pulse) during ECHO and again during HOLDOFF: no change to the current echo, no error pulse, no second measurement.
  - Change `echo_width_i` from 100 to 7 during DELAY: the echo is still 100 cycles.
- Reset mid-echo: assert `rst`=0 for 3 cycles, 40 cycles into a 100-cycle echo.
  - Required: `echo_o` drops immediately, and no echo follows.
  - Required: a subsequent valid trigger with width 50 produces a 50-cycle echo.
- Stuck trigger: `trig_i` held high from before reset release through 200 cycles.
  - Required: no echo.
  - Required: after it drops and rises again for 12 cycles, one normal measurement occurs.

Source files
------------

// File: rtl/ultrasonic_sensor_model.sv
// HC-SR04-style ranging sensor responder: qualifies a trigger pulse and answers
// with an echo whose width in clk cycles comes from echo_width_i.
module ultrasonic_sensor_model #(
  parameter int MIN_TRIG_CYCLES = 250,
  parameter int DELAY_CYCLES    = 5000,
  parameter int ECHO_TIMEOUT    = 950000,
  parameter int HOLDOFF_CYCLES  = 250000,
  parameter int WIDTH           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_i,
  input  logic [WIDTH-1:0] echo_width_i,
  output logic             echo_o,
  output logic             busy_o,
  output logic             trig_err_o
);

  localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_TRIG     = WIDTH'(MIN_TRIG_CYCLES);
  localparam logic [WIDTH-1:0] TIMEOUT      = WIDTH'(ECHO_TIMEOUT);
  localparam logic [WIDTH-1:0] DELAY_LAST   = WIDTH'(DELAY_CYCLES - 1);
  localparam logic [WIDTH-1:0] HOLDOFF_LAST = WIDTH'(HOLDOFF_CYCLES - 1);

  // state   | meaning
  // IDLE    | waiting for a trigger rise
  // TRIG    | measuring trigger high time
  // DELAY   | simulated burst flight before echo
  // ECHO    | echo_o high for the latched width
  // HOLDOFF | quiet time, triggers ignored
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_DELAY, S_ECHO, S_HOLDOFF} state_t;

  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic [1:0]       r_vld;
  logic             r_armed;
  logic [WIDTH-1:0] r_trig_cnt;
  logic [WIDTH-1:0] r_tmr;
  logic [WIDTH-1:0] r_width;
  logic             r_echo, r_busy, r_err;

  logic             w_rise, w_fall;
  logic [WIDTH-1:0] w_width;

  // A rise only counts once a genuine low has been sampled after reset, so a
  // trigger stuck high across reset release needs a fresh rise.
  assign w_rise = r_s2 & ~r_s3 & r_armed;
  assign w_fall = ~r_s2 & r_s3;

  always_comb begin
    w_width = echo_width_i;
    if (echo_width_i == '0 || echo_width_i > TIMEOUT) w_width = TIMEOUT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_vld      <= 2'b00;
      r_armed    <= 1'b0;
      r_trig_cnt <= '0;
      r_tmr      <= '0;
      r_width    <= '0;
      r_echo     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_s1  <= trig_i;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_vld <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_s2) r_armed <= 1'b1;
      r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state    <= S_TRIG;
            r_trig_cnt <= ONE;
          end
        end
        S_TRIG: begin
          if (w_fall) begin
            r_trig_cnt <= '0;
            if (r_trig_cnt >= MIN_TRIG) begin
              r_width <= w_width;
              r_tmr   <= DELAY_LAST;
              r_busy  <= 1'b1;
              r_state <= S_DELAY;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else if (r_s2 && r_trig_cnt < MIN_TRIG) begin
            r_trig_cnt <= r_trig_cnt + ONE;
          end
        end
        S_DELAY: begin
          if (r_tmr == '0) begin
            r_echo  <= 1'b1;
            r_tmr   <= r_width - ONE;
            r_state <= S_ECHO;
          end else begin
            r_tmr <= r_tmr - ONE;
          end
        end
        S_ECHO: begin
          if (r_tmr == '0) begin
            r_echo  <= 1'b0;
            r_tmr   <= HOLDOFF_LAST;
            r_state <= S_HOLDOFF;
          end else begin
            r_tmr <= r_tmr - ONE;
          end
        end
        S_HOLDOFF: begin
          if (r_tmr == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr - ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign echo_o     = r_echo;
  assign busy_o     = r_busy;
  assign trig_err_o = r_err;

endmodule

// File: tb/tb_ultrasonic_sensor_model.sv
// Bench for ultrasonic_sensor_model: directed scenarios plus random triggers,
// checked every cycle against a window-based model of the echo timing.
module tb_ultrasonic_sensor_model;
  localparam int MIN  = 10;
  localparam int DLY  = 8;
  localparam int TOUT = 1000;
  localparam int HOLD = 20;
  localparam int W    = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         trig = 1'b0;
  logic [W-1:0] width = '0;
  logic         echo, busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ultrasonic_sensor_model #(
    .MIN_TRIG_CYCLES(MIN), .DELAY_CYCLES(DLY), .ECHO_TIMEOUT(TOUT),
    .HOLDOFF_CYCLES(HOLD), .WIDTH(W)
  ) dut (
    .clk(clk), .rst(rst), .trig_i(trig), .echo_width_i(width),
    .echo_o(echo), .busy_o(busy), .trig_err_o(err)
  );

  // Model: edge k counts rising edges since reset release; t0..t3 are the trigger
  // samples at edges k..k-3. A pulse whose first low sample is edge N is judged at
  // edge N+2 and, if valid, defines output windows as edge intervals.
  int k, k_rise, b_rise, b_fall, e_rise, e_fall, err_edge, p_len, w_lat;
  bit t0, t1, t2, t3, in_trig;
  bit exp_e, exp_b, exp_r;

  function automatic int clamp_width(input int v);
    return (v == 0 || v > TOUT) ? TOUT : v;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      k = 0; t0 = 0; t1 = 0; t2 = 0; t3 = 0; in_trig = 0;
      b_rise = 0; b_fall = 0; e_rise = 0; e_fall = 0; err_edge = -1;
    end else begin
      k++;
      t3 = t2; t2 = t1; t1 = t0; t0 = trig;
      if (in_trig) begin
        if (k >= 4 && t3 && !t2) begin
          in_trig = 0;
          p_len = k - k_rise;
          if (p_len >= MIN) begin
            w_lat  = clamp_width(int'(width));
            b_rise = k;
            e_rise = k + DLY;
            e_fall = e_rise + w_lat;
            b_fall = e_fall + HOLD;
          end else begin
            err_edge = k;
          end
        end
      end else if (k >= 4 && t2 && !t3 && k > b_fall) begin
        in_trig = 1;
        k_rise  = k;
      end
    end
    #1;
    exp_e = rst && k >= e_rise && k < e_fall;
    exp_b = rst && k >= b_rise && k < b_fall;
    exp_r = rst && k == err_edge;
    checks++;
    if ({echo, busy, err} !== {exp_e, exp_b, exp_r}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t edge=%0d echo/busy/err got %b%b%b expected %b%b%b",
               $time, k, echo, busy, err, exp_e, exp_b, exp_r);
    end
  end

  int echo_q[$];
  int run = 0;
  int err_pulses = 0;
  int busy_cycles = 0;

  always @(posedge clk) begin
    #1;
    if (!rst) run = 0;
    else begin
      if (echo) run++;
      else if (run > 0) begin
        echo_q.push_back(run);
        run = 0;
      end
      if (err) err_pulses++;
      if (busy) busy_cycles++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts edges until the selected output (0 echo, 1 busy, 2 err) equals val.
  task automatic wait_sig(input int sel, input bit val, input int limit,
                          input string name, output int n);
    bit s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      s = (sel == 0) ? echo : (sel == 1) ? busy : err;
    end while (s !== val && n < limit);
    if (s !== val) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, got %b expected %b", name, n, s, val);
      n = -1;
    end
  endtask

  task automatic pulse(input int n);
    @(negedge clk);
    trig = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_width();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return '0;
    if (r == 1) return W'($urandom_range(1001, 3000));
    if (r == 2) return W'(TOUT);
    return W'($urandom_range(1, 40));
  endfunction

  initial begin
    int n, q0, e0, b0, gap;
    int cw[2];
    cw = '{0, 5000};

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({echo, busy, err}), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // valid trigger
    width = 100;
    pulse(10);
    @(posedge clk); #1;
    wait_sig(0, 1'b1, 50, "valid_rise", n);     chk("valid_delay", n, 10);
    wait_sig(0, 1'b0, 200, "valid_fall", n);    chk("valid_width", n, 100);
    wait_sig(1, 1'b0, 100, "valid_busy", n);    chk("valid_holdoff", n, 20);

    // short trigger
    repeat (5) @(negedge clk);
    e0 = err_pulses; q0 = echo_q.size(); b0 = busy_cycles;
    pulse(9);
    wait_sig(2, 1'b1, 20, "short_err", n);      chk("short_err_latency", n, 3);
    @(posedge clk); #1;
    chk("short_err_one_cycle", int'(err), 0);
    repeat (30) @(negedge clk);
    chk("short_err_count", err_pulses - e0, 1);
    chk("short_no_echo", echo_q.size() - q0, 0);
    chk("short_no_busy", busy_cycles - b0, 0);

    // timeout clamp
    foreach (cw[i]) begin
      width = W'(cw[i]);
      pulse(10);
      wait_sig(0, 1'b1, 50, "clamp_rise", n);
      wait_sig(0, 1'b0, 1100, "clamp_fall", n);
      chk($sformatf("clamp_width_%0d", cw[i]), n, 1000);
      wait_sig(1, 1'b0, 50, "clamp_busy", n);
      repeat (5) @(negedge clk);
    end

    // ignored retriggers and width latch point
    q0 = echo_q.size(); e0 = err_pulses;
    width = 100;
    pulse(10);
    repeat (3) @(negedge clk);
    width = 7;
    wait_sig(0, 1'b1, 50, "latch_rise", n);
    repeat (20) @(negedge clk);
    pulse(15);
    wait_sig(0, 1'b0, 200, "latch_fall", n);
    repeat (2) @(negedge clk);
    pulse(15);
    wait_sig(1, 1'b0, 50, "latch_busy", n);
    repeat (30) @(negedge clk);
    chk("latch_count", echo_q.size() - q0, 1);
    if (echo_q.size() > q0) chk("latch_width", echo_q[echo_q.size() - 1], 100);
    chk("ignore_err", err_pulses - e0, 0);

    // reset mid-echo
    width = 100;
    pulse(10);
    wait_sig(0, 1'b1, 50, "rst_rise", n);
    repeat (40) @(negedge clk);
    chk("rst_echo_pre", int'(echo), 1);
    q0 = echo_q.size();
    rst = 1'b0;
    #1;
    chk("rst_echo_drop", int'(echo), 0);
    chk("rst_busy_drop", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (150) @(negedge clk);
    chk("rst_no_echo", echo_q.size() - q0, 0);
    width = 50;
    pulse(10);
    wait_sig(0, 1'b1, 50, "rst_next_rise", n);
    wait_sig(0, 1'b0, 100, "rst_next_fall", n);
    chk("rst_next_width", n, 50);
    wait_sig(1, 1'b0, 50, "rst_next_busy", n);

    // trigger stuck high across reset release
    @(negedge clk);
    rst = 1'b0;
    trig = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q0 = echo_q.size(); b0 = busy_cycles; e0 = err_pulses;
    repeat (200) @(negedge clk);
    chk("stuck_no_echo", echo_q.size() - q0, 0);
    chk("stuck_no_busy", busy_cycles - b0, 0);
    trig = 1'b0;
    repeat (5) @(negedge clk);
    chk("stuck_no_err", err_pulses - e0, 0);
    width = 30;
    pulse(12);
    wait_sig(0, 1'b1, 50, "stuck_rise", n);
    wait_sig(0, 1'b0, 100, "stuck_fall", n);
    chk("stuck_width", n, 30);
    wait_sig(1, 1'b0, 50, "stuck_busy", n);
    repeat (10) @(negedge clk);
    chk("stuck_count", echo_q.size() - q0, 1);

    // random triggers, widths changing at arbitrary times
    repeat (30) begin
      width = rand_width();
      pulse($urandom_range(6, 14));
      gap = $urandom_range(0, 60);
      repeat (gap) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) width = rand_width();
      end
    end
    wait_sig(1, 1'b0, 3000, "final_drain", n);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
